// File: rtl/irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Machine-mode interrupt controller. Round-robin pick of masked
//            level requests, trap-entry strobe and cause, mret-driven ack.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int N_IRQ      = 16,
    parameter int CAUSE_BASE = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_IRQ-1:0]  irq_req_i,
    input  logic [31:0]       mie_i,
    input  logic              stall_i,
    input  logic              mret_i,
    output logic              trap_o,
    output logic [31:0]       mcause_o,
    output logic [N_IRQ-1:0]  irq_ret_o,
    output logic              busy_o
);

    localparam int IDXW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [31:0] c_int_flag = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAP    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RET     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_idx;
    logic              r_trap;
    logic [31:0]       r_mcause;
    logic [N_IRQ-1:0]  r_irq_ret;
    logic              r_busy;

    logic [N_IRQ-1:0]  w_pending;
    logic [N_IRQ-1:0]  w_rot;
    logic              w_any;
    logic [IDXW-1:0]   w_off;
    logic [IDXW:0]     w_sum;
    logic [IDXW:0]     w_nxt_sum;
    logic [IDXW-1:0]   w_pick;
    logic [IDXW-1:0]   w_ptr_nxt;
    logic              w_grant;
    logic [31:0]       w_cause;
    logic [N_IRQ-1:0]  w_ack;
    logic              w_unused;

    // Only the mie window belonging to the external lines is consulted.
    assign w_pending = irq_req_i & mie_i[CAUSE_BASE +: N_IRQ];
    assign w_unused  = ^mie_i;

    // Rotate so that bit 0 is the line at ptr; the lowest set bit is the winner.
    assign w_rot = N_IRQ'({w_pending, w_pending} >> r_ptr);

    always_comb begin
        w_any     = |w_rot;
        w_off     = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDXW'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDXW+1)'(N_IRQ)) begin
            w_sum = w_sum - (IDXW+1)'(N_IRQ);
        end
        w_pick    = w_sum[IDXW-1:0];
        w_nxt_sum = {1'b0, w_pick} + (IDXW+1)'(1);
        if (w_nxt_sum >= (IDXW+1)'(N_IRQ)) begin
            w_nxt_sum = '0;
        end
        w_ptr_nxt = w_nxt_sum[IDXW-1:0];
    end

    assign w_cause = c_int_flag | (32'(CAUSE_BASE) + 32'(w_pick));
    assign w_ack   = N_IRQ'(1) << r_idx;
    assign w_grant = (r_state == ST_IDLE) && w_any && !stall_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_any && !stall_i) w_state_nxt = ST_TRAP;
            ST_TRAP:    w_state_nxt = ST_HANDLER;
            ST_HANDLER: if (mret_i) w_state_nxt = ST_RET;
            ST_RET:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_trap    <= 1'b0;
            r_mcause  <= '0;
            r_irq_ret <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_trap    <= (w_state_nxt == ST_TRAP);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_irq_ret <= (w_state_nxt == ST_RET) ? w_ack : '0;
            if (w_grant) begin
                r_idx    <= w_pick;
                r_ptr    <= w_ptr_nxt;
                r_mcause <= w_cause;
            end
        end
    end

    assign trap_o    = r_trap;
    assign mcause_o  = r_mcause;
    assign irq_ret_o = r_irq_ret;
    assign busy_o    = r_busy;

endmodule
`default_nettype wire
